// File: rtl/spi_sched_pkg.sv
// Shared types and default parameters for the round-robin SPI scheduler.
package spi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam int unsigned N_REQ_DEF          = 4;
    localparam int unsigned DATA_W_DEF         = 8;
    localparam int unsigned SETUP_CYCLES_DEF   = 2;
    localparam int unsigned GAP_CYCLES_DEF     = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    // Largest of the three phase lengths, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first set req bit at or after ptr (with wrap) wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] winner
);
    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/spi_rr_scheduler.sv
// Shares one SPI master between N_REQ requesters: round-robin grant, CS ownership,
// single-byte launch, and ack / watchdog-error reporting per requester.
module spi_rr_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned N_REQ          = N_REQ_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned SETUP_CYCLES   = SETUP_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          err,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_busy,
    input  logic                      m_done,
    output logic [N_REQ-1:0]          cs_n,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(max3(SETUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic              m_start_q, m_start_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [N_REQ-1:0]  cs_n_q, cs_n_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;

    logic              arb_valid;
    logic [ID_W-1:0]   arb_winner;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // Byte of the current arbitration winner.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_winner == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and registered-output logic; the counter only decrements from non-zero.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = '0;
        m_start_d = 1'b0;
        m_data_d  = m_data_q;
        cs_n_d    = cs_n_q;
        grant_d   = grant_q;

        unique case (state_q)
            IDLE: begin
                if (arb_valid && !m_busy) begin
                    grant_d  = arb_winner;
                    m_data_d = sel_data;
                    cs_n_d   = ~(N_REQ'(1) << arb_winner);
                    cnt_d    = SETUP_LOAD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!m_busy) begin
                    m_start_d = 1'b1;
                    cnt_d     = TIMEOUT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_done || cnt_q == '0) begin
                    if (m_done) ack_d = N_REQ'(1) << grant_q;
                    else        err_d = N_REQ'(1) << grant_q;
                    cs_n_d  = '1;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            m_start_q <= 1'b0;
            m_data_q  <= '0;
            cs_n_q    <= '1;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            m_start_q <= m_start_d;
            m_data_q  <= m_data_d;
            cs_n_q    <= cs_n_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign m_start  = m_start_q;
    assign m_data   = m_data_q;
    assign cs_n     = cs_n_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_rr_scheduler.sv
// Scoreboard bench for spi_rr_scheduler: a transaction-level round-robin model predicts
// grant order, data, start latency and ack/err outcome; a monitor checks the DUT against it.
module tb_spi_rr_scheduler;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int SETUP   = 2;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          id;
        logic [7:0]  data;
        bit          is_err;
        int          start_dly;
    } exp_t;

    logic            clk, rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack, err, cs_n;
    logic            m_start, m_busy, m_done;
    logic [DW-1:0]   m_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            mb_master, mb_hold;

    exp_t       sb[$];
    int         delays[$];
    int         holds[$];
    logic [7:0] rd[N];
    int         model_ptr;
    int         n_checks, n_fail;

    assign m_busy = mb_master | mb_hold;

    spi_rr_scheduler #(
        .N_REQ(N), .DATA_W(DW), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack), .err(err),
        .m_start(m_start), .m_data(m_data), .m_busy(m_busy), .m_done(m_done),
        .cs_n(cs_n), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_winner(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return TIMEOUT;
        if (r == 1) return int'($urandom_range(TIMEOUT + 1, TIMEOUT + 8));
        return int'($urandom_range(1, TIMEOUT - 1));
    endfunction

    // Predict the transactions produced by a batch of requests (fix_* < 0 means random).
    task automatic plan(input logic [N-1:0] mask, input int n, input bit sticky,
                        input int fix_dly, input int fix_hold);
        logic [N-1:0] m;
        m = mask;
        for (int t = 0; t < n; t++) begin
            exp_t e;
            int   w, d, h;
            w = next_winner(m, model_ptr);
            d = (fix_dly >= 0) ? fix_dly : pick_delay();
            if (fix_hold >= 0) h = fix_hold;
            else h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            e.id        = w;
            e.data      = rd[w];
            e.is_err    = (d > TIMEOUT);
            e.start_dly = (h + 1 > SETUP) ? h + 1 : SETUP;
            sb.push_back(e);
            delays.push_back(d);
            holds.push_back(h);
            if (!sticky) m[w] = 1'b0;
            model_ptr = (w + 1) % N;
        end
    endtask

    // Drive requests; each requester drops req on its ack/err unless sticky.
    task automatic run(input logic [N-1:0] mask, input int n, input bit sticky);
        int got, budget;
        got = 0;
        budget = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rd[i];
        req = mask;
        while (got < n && budget < 3000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < N; i++) begin
                if (ack[i] || err[i]) begin
                    got++;
                    if (!sticky) req[i] = 1'b0;
                end
                if (!sticky && !cs_n[i] && req[i]) req_data[i*DW +: DW] = 8'($urandom);
            end
        end
        req = '0;
        check("batch_complete", 32'(got), 32'(n));
        repeat (GAP + 3) @(negedge clk);
    endtask

    // SPI master model: done d cycles after the start pulse it sees (never sampled past the watchdog).
    initial begin : master
        int k;
        mb_master = 1'b0;
        m_done    = 1'b0;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                k = (delays.size() > 0) ? delays.pop_front() : 5;
                mb_master = 1'b1;
                for (int j = 1; j < k; j++) @(negedge clk);
                m_done = 1'b1;
                @(negedge clk);
                m_done    = 1'b0;
                mb_master = 1'b0;
            end
        end
    end

    // Holds m_busy high for a planned number of cycles right after each grant.
    initial begin : holdoff
        logic [N-1:0] prev;
        int h;
        prev    = '1;
        mb_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (prev == '1 && cs_n != '1) begin
                h = (holds.size() > 0) ? holds.pop_front() : 0;
                if (h > 0) begin
                    mb_hold = 1'b1;
                    repeat (h) @(negedge clk);
                    mb_hold = 1'b0;
                end
            end
            prev = cs_n;
        end
    end

    initial begin : monitor
        bit           in_xfer, started;
        int           cyc_g, cyc_s;
        exp_t         cur;
        logic [N-1:0] exp_cs, exp_ack, exp_err;
        in_xfer = 0;
        started = 0;
        cyc_g   = 0;
        cyc_s   = 0;
        cur     = '{0, 8'h00, 1'b0, 0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_xfer = 0;
                started = 0;
                continue;
            end
            check("cs_onecold", 32'($countones(~cs_n) <= 1), 32'd1);
            if (in_xfer) cyc_g++;
            if (started) cyc_s++;
            if (!in_xfer && cs_n != '1) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 32'(sb.size()), 32'd1);
                end else begin
                    cur    = sb[0];
                    exp_cs = '1;
                    exp_cs[cur.id] = 1'b0;
                    check("grant_cs_n", 32'(cs_n), 32'(exp_cs));
                    check("grant_id", 32'(grant_id), 32'(cur.id));
                    check("grant_data", 32'(m_data), 32'(cur.data));
                    check("grant_busy", 32'(busy), 32'd1);
                end
                in_xfer = 1;
                cyc_g   = 0;
                started = 0;
            end
            if (m_start) begin
                check("start_once", {30'd0, in_xfer, started}, 32'd2);
                check("start_latency", 32'(cyc_g), 32'(cur.start_dly));
                started = 1;
                cyc_s   = 0;
            end
            if (ack != '0 || err != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'({ack, err}), 32'd0);
                end else begin
                    cur     = sb.pop_front();
                    exp_ack = '0;
                    exp_err = '0;
                    if (cur.is_err) exp_err[cur.id] = 1'b1;
                    else            exp_ack[cur.id] = 1'b1;
                    check("resp_ack", 32'(ack), 32'(exp_ack));
                    check("resp_err", 32'(err), 32'(exp_err));
                    check("gap_cs_n", 32'(cs_n), 32'hF);
                    check("data_held", 32'(m_data), 32'(cur.data));
                    if (cur.is_err) check("timeout_cycles", 32'(cyc_s), 32'(TIMEOUT));
                    else            check("ack_after_done", 32'(m_done), 32'd1);
                end
                in_xfer = 0;
                started = 0;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, 32'(cs_n), 32'hF);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_m_start"}, 32'(m_start), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) rd[i] = 8'($urandom);
    endtask

    // Reset asserted mid-WAIT; afterwards the lowest set index must win.
    task automatic reset_mid_wait();
        logic [N-1:0] mask;
        exp_t e;
        int   w, budget;
        mask = 4'b0110;
        randomize_data();
        w = next_winner(mask, model_ptr);
        e.id = w; e.data = rd[w]; e.is_err = 1'b0; e.start_dly = SETUP;
        sb.push_back(e);
        holds.push_back(0);
        delays.push_back(10);
        @(negedge clk);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rd[i];
        req = mask;
        budget = 0;
        while (m_start !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("reset_test_started", 32'(m_start), 32'd1);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        sb.delete();
        model_ptr = 0;
        plan(mask, 2, 1'b0, 10, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(mask, 2, 1'b0);
    endtask

    initial begin : stimulus
        logic [N-1:0] mask;
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        randomize_data();
        plan(4'b1111, 5, 1'b1, 10, 0);
        run(4'b1111, 5, 1'b1);

        randomize_data();
        rd[2] = 8'hA5;
        plan(4'b0100, 1, 1'b0, 10, 0);
        run(4'b0100, 1, 1'b0);

        randomize_data();
        plan(4'b0011, 2, 1'b0, TIMEOUT + 4, 0);
        run(4'b0011, 2, 1'b0);

        randomize_data();
        plan(4'b1000, 1, 1'b0, TIMEOUT, 0);
        run(4'b1000, 1, 1'b0);

        randomize_data();
        plan(4'b0010, 1, 1'b0, 6, 4);
        run(4'b0010, 1, 1'b0);

        reset_mid_wait();

        for (int b = 0; b < 30; b++) begin
            mask = 4'($urandom_range(1, 15));
            randomize_data();
            plan(mask, $countones(mask), 1'b0, -1, -1);
            run(mask, $countones(mask), 1'b0);
        end

        repeat (30) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
